seq_div_unit: RTL and testbench

- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Consumes the datapath's carry-lookahead arithmetic in the reverse role: it does repeated trial subtraction and uses the borrow-out as the quotient bit.
- Sits beside the ALU in EX and stalls the pipeline via ready/done.
- One quotient bit per cycle; operands are latched at start.

---
 rtl/div_pkg.sv | 31 +++
 rtl/cla_sub_n.sv | 58 +++++
 rtl/seq_div_unit.sv | 177 +++++++++++++++++
 tb/tb_seq_div_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider: op encodings, FSM states
// and the fixed latency of a full-length division.
package div_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DIV_LAT  = DEF_XLEN + 2;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  // DIV and REM have op[0]=0; the remainder-producing ops have op[1]=1.
  function automatic logic isSignedOp(input logic [1:0] opVal);
    return ~opVal[0];
  endfunction

  function automatic logic isRemOp(input logic [1:0] opVal);
    return opVal[1];
  endfunction

endpackage

// File: rtl/cla_sub_n.sv
// W-bit subtractor x - y computed as x + ~y + 1 with cascaded 4-bit carry-lookahead
// groups; borrow_o is the inverted carry out. A partial top group is allowed.
module cla_sub_n #(
  parameter int W = 33
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  localparam int NG = (W + 3) / 4;

  logic [W-1:0] gen;
  logic [W-1:0] tra;
  logic [W-1:0] prop;
  logic [W:0]   carry;
  logic         grpCin;
  logic         acc;
  logic         prodT;

  // Each bit carry is a sum of products over its own group, seeded by the group carry-in,
  // so only the group carries ripple from one group to the next.
  always_comb begin
    gen      = x_i & ~y_i;
    tra      = x_i | ~y_i;
    prop     = x_i ^ ~y_i;
    carry    = '0;
    carry[0] = 1'b1;
    grpCin   = 1'b0;
    acc      = 1'b0;
    prodT    = 1'b0;
    for (int grp = 0; grp < NG; grp++) begin
      grpCin = carry[grp*4];
      for (int i = 0; i < 4; i++) begin
        if (grp*4 + i < W) begin
          acc = 1'b0;
          for (int j = 0; j <= i; j++) begin
            prodT = 1'b1;
            for (int k = j + 1; k <= i; k++) begin
              prodT = prodT & tra[grp*4 + k];
            end
            acc = acc | (gen[grp*4 + j] & prodT);
          end
          prodT = 1'b1;
          for (int k = 0; k <= i; k++) begin
            prodT = prodT & tra[grp*4 + k];
          end
          carry[grp*4 + i + 1] = acc | (prodT & grpCin);
        end
      end
    end
  end

  assign diff_o   = prop ^ carry[W-1:0];
  assign borrow_o = ~carry[W];

endmodule

// File: rtl/seq_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define SEQ_DIV_EARLY_OUT_EN to finish in one cycle whenever |a| < |b|.
module seq_div_unit
  import div_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qSign_q, qSign_d;
  logic            rSign_q, rSign_d;

  logic            signedOp;
  logic            aNeg;
  logic            bNeg;
  logic [XLEN-1:0] absA;
  logic [XLEN-1:0] absB;
  logic            bIsZero;
  logic            overflow;
  logic            earlyOut;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] fixOperand;
  logic            fixNeg;
  logic [XLEN:0]   subX;
  logic [XLEN:0]   subY;
  logic [XLEN:0]   subDiff;
  logic            subBorrow;
  logic [XLEN-1:0] negBDiff;
  logic            negBBorrow;

  // One subtractor serves three roles by state: |a| in IDLE, trial subtract in RUN,
  // sign fix-up in FIX.
  cla_sub_n #(.W(XLEN + 1)) uSub (
    .x_i      (subX),
    .y_i      (subY),
    .diff_o   (subDiff),
    .borrow_o (subBorrow)
  );

  // 0 - b borrows exactly when b is non-zero, which doubles as the divide-by-zero detect.
  cla_sub_n #(.W(XLEN)) uNegB (
    .x_i      ('0),
    .y_i      (b),
    .diff_o   (negBDiff),
    .borrow_o (negBBorrow)
  );

  assign signedOp   = isSignedOp(op);
  assign aNeg       = signedOp & a[XLEN-1];
  assign bNeg       = signedOp & b[XLEN-1];
  assign absA       = aNeg ? subDiff[XLEN-1:0] : a;
  assign absB       = bNeg ? negBDiff : b;
  assign bIsZero    = ~negBBorrow;
  assign overflow   = signedOp & (a == MIN_NEG) & (b == '1);
  assign shifted    = (rem_q << 1) | {{XLEN{1'b0}}, quo_q[XLEN-1]};
  assign fixOperand = isRemOp(op_q) ? rem_q[XLEN-1:0] : quo_q;
  assign fixNeg     = isRemOp(op_q) ? rSign_q : qSign_q;

`ifdef SEQ_DIV_EARLY_OUT_EN
  assign earlyOut = (absA < absB);
`else
  assign earlyOut = 1'b0;
`endif

  always_comb begin
    subX = '0;
    subY = {1'b0, a};
    case (state_q)
      RUN: begin
        subX = shifted;
        subY = {1'b0, divisor_q};
      end
      FIX:     subY = {1'b0, fixOperand};
      default: subY = {1'b0, a};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    qSign_d   = qSign_q;
    rSign_d   = rSign_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op;
          if (bIsZero) begin
            result_d = isRemOp(op) ? a : '1;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = isRemOp(op) ? '0 : a;
            state_d  = DONE;
          end else if (earlyOut) begin
            result_d = isRemOp(op) ? a : '0;
            state_d  = DONE;
          end else begin
            rem_d     = '0;
            quo_d     = absA;
            divisor_d = absB;
            qSign_d   = aNeg ^ bNeg;
            rSign_d   = aNeg;
            cnt_d     = CW'(XLEN - 1);
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        rem_d = subBorrow ? shifted : subDiff;
        quo_d = {quo_q[XLEN-2:0], ~subBorrow};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        result_d = fixNeg ? subDiff[XLEN-1:0] : fixOperand;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      qSign_q   <= 1'b0;
      rSign_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      qSign_q   <= qSign_d;
      rSign_q   <= rSign_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: directed vector table, corner-case sequences
// and randomized operations checked against an arithmetic reference model.
module tb_seq_div_unit;
  import div_pkg::*;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 200;
`ifdef SEQ_DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = DIV_LAT;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op    = 2'b00;
  logic [XLEN-1:0] a     = '0;
  logic [XLEN-1:0] b     = '0;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [1:0]  vOp;
    logic [31:0] vA;
    logic [31:0] vB;
    logic [31:0] expResult;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  seq_div_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: plain language-level division with the RISC-V rules for the special cases.
  function automatic logic [31:0] refResult(input logic [1:0] fOp, input logic [31:0] fa,
                                            input logic [31:0] fb);
    int sa;
    int sb;
    sa = fa;
    sb = fb;
    if (fb == 32'd0) return fOp[1] ? fa : 32'hFFFF_FFFF;
    case (fOp)
      2'b00: begin
        if (fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) return fa;
        return sa / sb;
      end
      2'b01: return fa / fb;
      2'b10: begin
        if (fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return fa % fb;
    endcase
  endfunction

  function automatic int refLatency(input logic [1:0] fOp, input logic [31:0] fa,
                                    input logic [31:0] fb);
`ifdef SEQ_DIV_EARLY_OUT_EN
    longint ma;
    longint mb;
`endif
    if (fb == 32'd0) return 1;
    if (!fOp[0] && fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) return 1;
`ifdef SEQ_DIV_EARLY_OUT_EN
    ma = longint'(fa);
    mb = longint'(fb);
    if (!fOp[0] && fa[31]) ma = 64'd4294967296 - longint'(fa);
    if (!fOp[0] && fb[31]) mb = 64'd4294967296 - longint'(fb);
    if (ma < mb) return 1;
`endif
    return DIV_LAT;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic [1:0] vOp, input logic [31:0] vA, input logic [31:0] vB,
                        input logic [31:0] expResult, input int expLat);
    vec_t v;
    v.vOp       = vOp;
    v.vA        = vA;
    v.vB        = vB;
    v.expResult = expResult;
    v.expLat    = expLat;
    vecs.push_back(v);
  endtask

  // Starts one operation and returns the result seen with done plus the latency in cycles,
  // counting the start edge as cycle 1. Inputs are scrambled afterwards to prove latching.
  task automatic applyStimulus(input logic [1:0] vOp, input logic [31:0] vA,
                               input logic [31:0] vB, output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    while (!ready && guard < TIMEOUT) begin
      @(posedge clk);
      #1;
      guard++;
    end
    op    = vOp;
    a     = vA;
    b     = vB;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = $urandom;
    b     = $urandom;
    lat   = 1;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    logic [1:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;
    logic        sawDone;

    addVec(OP_DIVU, 32'd100,       32'd7,         32'd14,        DIV_LAT);
    addVec(OP_REMU, 32'd100,       32'd7,         32'd2,         DIV_LAT);
    addVec(OP_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, DIV_LAT);
    addVec(OP_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, DIV_LAT);
    addVec(OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    addVec(OP_REMU, 32'd5,         32'd0,         32'd5,         1);
    addVec(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    addVec(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    addVec(OP_DIVU, 32'd3,         32'd10,        32'd0,         EO_LAT);
    addVec(OP_REM,  32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, EO_LAT);
    addVec(OP_DIV,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFE, DIV_LAT);
    addVec(OP_REM,  32'd7,         32'hFFFF_FFFD, 32'd1,         DIV_LAT);
    addVec(OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, DIV_LAT);
    addVec(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         DIV_LAT);
    addVec(OP_DIV,  32'h8000_0000, 32'd2,         32'hC000_0000, DIV_LAT);
    addVec(OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
    addVec(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         EO_LAT);

    // Reset values while rst_n is held low.
    #2;
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", result, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle ready after reset", 32'(ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].vOp, vecs[i].vA, vecs[i].vB, res, lat);
      checkOutput($sformatf("vec%0d result", i), res, vecs[i].expResult);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d result held", i), result, vecs[i].expResult);
      checkOutput($sformatf("vec%0d ready after done", i), 32'(ready), 32'd1);
    end

    // start asserted during the DONE cycle must not be accepted.
    applyStimulus(OP_DIVU, 32'd50, 32'd5, res, lat);
    checkOutput("pre-done-start result", res, 32'd10);
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd9;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("start in DONE ignored (ready)", 32'(ready), 32'd1);
    checkOutput("start in DONE ignored (result)", result, 32'd10);

    // A second start pulse mid-operation is dropped.
    op    = OP_DIVU;
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < TIMEOUT) begin
      if (lat == 5) begin
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    checkOutput("second start ignored result", result, 32'd333);
    checkOutput("second start ignored latency", 32'(lat), 32'(DIV_LAT));
    @(posedge clk);
    #1;

    // Reset in the middle of an operation aborts it without a done pulse.
    op    = OP_DIVU;
    a     = 32'h0000_FFFF;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    sawDone = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
      sawDone = sawDone | done;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort ready", 32'(ready), 32'd1);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort result cleared", result, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (DIV_LAT + 4) begin
      @(posedge clk);
      #1;
      sawDone = sawDone | done;
    end
    checkOutput("no done after abort", 32'(sawDone), 32'd0);

    // Randomized operations with a bias toward the special-case boundaries.
    for (int i = 0; i < 40; i++) begin
      rOp = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin rA = $urandom; rB = 32'd0; end
        1: begin rA = 32'h8000_0000; rB = 32'hFFFF_FFFF; end
        2: begin rA = $urandom; rB = 32'($urandom_range(1, 15)); end
        3: begin rB = $urandom; rA = rB >> $urandom_range(1, 8); end
        4: begin rA = 32'($urandom_range(0, 255)); rB = 32'hFFFF_FF00 | 32'($urandom_range(1, 255)); end
        default: begin rA = $urandom; rB = $urandom >> $urandom_range(0, 24); end
      endcase
      applyStimulus(rOp, rA, rB, res, lat);
      checkOutput($sformatf("rand%0d op%0d 0x%08h/0x%08h result", i, rOp, rA, rB), res,
                  refResult(rOp, rA, rB));
      checkOutput($sformatf("rand%0d latency", i), 32'(lat), 32'(refLatency(rOp, rA, rB)));
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
